conv_transposed_3d_tap_scheduler: RTL and testbench

Upstream sequencer for the 3D transposed-convolution datapath (square input, square kernel, padding, dilation, stride). For each input voxel and kernel tap it computes the scattered output coordinate, drops taps that fall outside the output volume, and streams the surviving (input address, weight address, output address) triples to the MAC/accumulate stage through a valid/ready handshake. One tap candidate is evaluated per cycle. Stalls come only from downstream backpressure.

---
 rtl/conv_transposed_3d_tap_scheduler_pkg.sv | 24 ++
 rtl/conv_transposed_3d_tap_scheduler_if.sv | 31 +++
 rtl/conv_transposed_3d_tap_scheduler_axis_map.sv | 27 ++
 rtl/conv_transposed_3d_tap_scheduler.sv | 175 +++++++++++++++++
 tb/tb_conv_transposed_3d_tap_scheduler.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_transposed_3d_tap_scheduler_pkg.sv
// Shared definitions for the 3D transposed-conv tap scheduler.
// Output edge length and address widths used by producer and MAC stage.
package conv_t3d_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int out_dim(
    input int n,
    input int k,
    input int s,
    input int p,
    input int d
  );
    return (n - 1) * s - 2 * p + d * (k - 1) + 1;
  endfunction

  function automatic int addr_w(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/conv_transposed_3d_tap_scheduler_if.sv
// Tap-triple stream between the scheduler and the MAC stage.
// Single-entry valid/ready handshake carrying three addresses.
interface conv_transposed_3d_tap_scheduler_if #(
  parameter int IN_AW  = 1,
  parameter int W_AW   = 1,
  parameter int OUT_AW = 1
) ();

  logic              valid_out;
  logic              ready_in;
  logic [IN_AW-1:0]  in_addr;
  logic [W_AW-1:0]   w_addr;
  logic [OUT_AW-1:0] out_addr;

  modport master (
    output valid_out,
    output in_addr,
    output w_addr,
    output out_addr,
    input  ready_in
  );

  modport slave (
    input  valid_out,
    input  in_addr,
    input  w_addr,
    input  out_addr,
    output ready_in
  );

endinterface

// File: rtl/conv_transposed_3d_tap_scheduler_axis_map.sv
// Per-axis scatter map: o = i*STRIDE + k*DIL - PAD.
// Flags whether the output coordinate lands inside [0, OUT).
module conv_t3d_axis_map #(
  parameter int STRIDE = 2,
  parameter int PAD    = 1,
  parameter int DIL    = 2,
  parameter int OUT    = 16,
  parameter int IB     = 3,
  parameter int KB     = 2,
  parameter int OB     = 4
) (
  input  logic [IB-1:0] i,
  input  logic [KB-1:0] k,
  output logic [OB-1:0] o,
  output logic          in_bounds
);

  int o_s;

  // signed coordinate, bounds test and truncation to the output index
  always_comb begin
    o_s       = int'(i) * STRIDE + int'(k) * DIL - PAD;
    in_bounds = (o_s >= 0) && (o_s < OUT);
    o         = OB'(o_s);
  end

endmodule

// File: rtl/conv_transposed_3d_tap_scheduler.sv
// Tap scheduler: walks c,id,ih,iw,kd,kh,kw and emits in-bounds
// (input, weight, output) address triples, one candidate per cycle.
module conv_transposed_3d_tap_scheduler
  import conv_t3d_pkg::*;
#(
  parameter int C_IN   = 4,
  parameter int N      = 8,
  parameter int K      = 3,
  parameter int STRIDE = 2,
  parameter int PAD    = 1,
  parameter int DIL    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] tap_count,
  conv_transposed_3d_tap_scheduler_if.master tap
);

  localparam int OUT    = out_dim(N, K, STRIDE, PAD, DIL);
  localparam int IN_AW  = addr_w(C_IN * N * N * N);
  localparam int W_AW   = addr_w(C_IN * K * K * K);
  localparam int OUT_AW = addr_w(OUT * OUT * OUT);
  localparam int CB     = addr_w(C_IN);
  localparam int NB     = addr_w(N);
  localparam int KB     = addr_w(K);
  localparam int OB     = addr_w(OUT);

  localparam logic [IN_AW-1:0]  N_I = IN_AW'(N);
  localparam logic [W_AW-1:0]   K_W = W_AW'(K);
  localparam logic [OUT_AW-1:0] O_O = OUT_AW'(OUT);

  logic [1:0]        state;
  logic [CB-1:0]     c;
  logic [NB-1:0]     id, ih, iw;
  logic [KB-1:0]     kd, kh, kw;
  logic [OB-1:0]     od, oh, ow;
  logic              ib_d, ib_h, ib_w, inb;
  logic              w_c, w_id, w_ih, w_iw;
  logic              w_kd, w_kh, w_kw;
  logic              cy_kd, cy_iw, cy_ih, cy_id, cy_c;
  logic              adv, last, xfer;
  logic              vld_q;
  logic [IN_AW-1:0]  in_q, in_n;
  logic [W_AW-1:0]   w_q, w_n;
  logic [OUT_AW-1:0] out_q, out_n;

  conv_t3d_axis_map #(
    .STRIDE(STRIDE), .PAD(PAD), .DIL(DIL), .OUT(OUT),
    .IB(NB), .KB(KB), .OB(OB)
  ) u_map_d (.i(id), .k(kd), .o(od), .in_bounds(ib_d));

  conv_t3d_axis_map #(
    .STRIDE(STRIDE), .PAD(PAD), .DIL(DIL), .OUT(OUT),
    .IB(NB), .KB(KB), .OB(OB)
  ) u_map_h (.i(ih), .k(kh), .o(oh), .in_bounds(ib_h));

  conv_t3d_axis_map #(
    .STRIDE(STRIDE), .PAD(PAD), .DIL(DIL), .OUT(OUT),
    .IB(NB), .KB(KB), .OB(OB)
  ) u_map_w (.i(iw), .k(kw), .o(ow), .in_bounds(ib_w));

  assign inb   = ib_d & ib_h & ib_w;
  assign w_c   = (c  == CB'(C_IN - 1));
  assign w_id  = (id == NB'(N - 1));
  assign w_ih  = (ih == NB'(N - 1));
  assign w_iw  = (iw == NB'(N - 1));
  assign w_kd  = (kd == KB'(K - 1));
  assign w_kh  = (kh == KB'(K - 1));
  assign w_kw  = (kw == KB'(K - 1));
  assign cy_kd = w_kw & w_kh;
  assign cy_iw = cy_kd & w_kd;
  assign cy_ih = cy_iw & w_iw;
  assign cy_id = cy_ih & w_ih;
  assign cy_c  = cy_id & w_id;
  assign last  = cy_c & w_c;

  assign xfer = vld_q & tap.ready_in;
  assign adv  = (state == ST_RUN) & (~vld_q | tap.ready_in);
  assign busy = (state == ST_RUN) | (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  assign tap.valid_out = vld_q;
  assign tap.in_addr   = in_q;
  assign tap.w_addr    = w_q;
  assign tap.out_addr  = out_q;

  // flattened addresses of the current candidate
  always_comb begin
    in_n  = ((IN_AW'(c) * N_I + IN_AW'(id)) * N_I
            + IN_AW'(ih)) * N_I + IN_AW'(iw);
    w_n   = ((W_AW'(c) * K_W + W_AW'(kd)) * K_W
            + W_AW'(kh)) * K_W + W_AW'(kw);
    out_n = (OUT_AW'(od) * O_O + OUT_AW'(oh)) * O_O
            + OUT_AW'(ow);
  end

  // pass sequencing and the carry-chained loop counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      c  <= '0;
      id <= '0;
      ih <= '0;
      iw <= '0;
      kd <= '0;
      kh <= '0;
      kw <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_RUN;
          c  <= '0;
          id <= '0;
          ih <= '0;
          iw <= '0;
          kd <= '0;
          kh <= '0;
          kw <= '0;
        end
        ST_RUN: if (adv) begin
          kw <= w_kw ? '0 : kw + KB'(1);
          if (w_kw)  kh <= w_kh ? '0 : kh + KB'(1);
          if (cy_kd) kd <= w_kd ? '0 : kd + KB'(1);
          if (cy_iw) iw <= w_iw ? '0 : iw + NB'(1);
          if (cy_ih) ih <= w_ih ? '0 : ih + NB'(1);
          if (cy_id) id <= w_id ? '0 : id + NB'(1);
          if (cy_c)  c  <= w_c  ? '0 : c  + CB'(1);
          if (last)  state <= ST_DRAIN;
        end
        ST_DRAIN: if (~vld_q | tap.ready_in) begin
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // single-entry output register, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      in_q  <= '0;
      w_q   <= '0;
      out_q <= '0;
    end else if (abort) begin
      vld_q <= 1'b0;
    end else if (adv & inb) begin
      vld_q <= 1'b1;
      in_q  <= in_n;
      w_q   <= w_n;
      out_q <= out_n;
    end else if (xfer) begin
      vld_q <= 1'b0;
    end
  end

  // accepted-triple counter, cleared when a pass starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_count <= '0;
    end else if (state == ST_IDLE && start && !abort) begin
      tap_count <= '0;
    end else if (xfer) begin
      tap_count <= tap_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_conv_transposed_3d_tap_scheduler.sv
// Directed bench for the tap scheduler: sequence, latency,
// backpressure, abort, async reset and ignored-start cases.
module tb_conv_transposed_3d_tap_scheduler;
  import conv_t3d_pkg::*;

  localparam int A_CIN = 1;
  localparam int A_N   = 2;
  localparam int A_K   = 3;
  localparam int A_S   = 2;
  localparam int A_P   = 1;
  localparam int A_D   = 2;
  localparam int A_OUT = out_dim(A_N, A_K, A_S, A_P, A_D);
  localparam int A_IAW = addr_w(A_CIN * A_N * A_N * A_N);
  localparam int A_WAW = addr_w(A_CIN * A_K * A_K * A_K);
  localparam int A_OAW = addr_w(A_OUT * A_OUT * A_OUT);

  localparam int B_CIN = 2;
  localparam int B_N   = 3;
  localparam int B_K   = 2;
  localparam int B_OUT = out_dim(B_N, B_K, 1, 0, 1);
  localparam int B_IAW = addr_w(B_CIN * B_N * B_N * B_N);
  localparam int B_WAW = addr_w(B_CIN * B_K * B_K * B_K);
  localparam int B_OAW = addr_w(B_OUT * B_OUT * B_OUT);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, abort_a, busy_a, done_a;
  logic        start_b, abort_b, busy_b, done_b;
  logic [31:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  conv_transposed_3d_tap_scheduler_if #(
    .IN_AW(A_IAW), .W_AW(A_WAW), .OUT_AW(A_OAW)
  ) tap_a ();

  conv_transposed_3d_tap_scheduler_if #(
    .IN_AW(B_IAW), .W_AW(B_WAW), .OUT_AW(B_OAW)
  ) tap_b ();

  conv_transposed_3d_tap_scheduler #(
    .C_IN(A_CIN), .N(A_N), .K(A_K),
    .STRIDE(A_S), .PAD(A_P), .DIL(A_D)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a),
    .tap_count(cnt_a), .tap(tap_a)
  );

  conv_transposed_3d_tap_scheduler #(
    .C_IN(B_CIN), .N(B_N), .K(B_K),
    .STRIDE(1), .PAD(0), .DIL(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b),
    .tap_count(cnt_b), .tap(tap_b)
  );

  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];
  int xi = 0;
  int first_t = -1;
  int n_done_a = 0;
  int nb = 0;
  int last_out_b = -1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  function automatic int pack(input int a, input int w, input int o);
    return (a << 16) | (w << 8) | o;
  endfunction

  // compare every presented triple of DUT A with the model sequence
  always @(negedge clk) begin
    if (done_a) n_done_a++;
    if (tap_a.valid_out) begin
      check("seq_a",
            pack(int'(tap_a.in_addr), int'(tap_a.w_addr),
                 int'(tap_a.out_addr)),
            (xi < exp_q.size()) ? exp_q[xi] : -1);
      if (tap_a.ready_in) begin
        if (xi == 0)
          first_t = pack(int'(tap_a.in_addr), int'(tap_a.w_addr),
                         int'(tap_a.out_addr));
        xi++;
      end
    end
  end

  // count DUT B transfers and remember the last output address
  always @(negedge clk) begin
    if (tap_b.valid_out && tap_b.ready_in) begin
      nb++;
      last_out_b = int'(tap_b.out_addr);
    end
  end

  task automatic pulse_start_a();
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, input bit rnd,
                             input bit poke, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done_a) begin
        lat = i;
        if (poke) start_a = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (rnd) tap_a.ready_in = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1 start_a = 1'b0;
    tap_a.ready_in = 1'b1;
  endtask

  initial begin
    int lat;
    int nd0;
    bit found;

    for (int c = 0; c < A_CIN; c++)
      for (int id = 0; id < A_N; id++)
        for (int ih = 0; ih < A_N; ih++)
          for (int iw = 0; iw < A_N; iw++)
            for (int kd = 0; kd < A_K; kd++)
              for (int kh = 0; kh < A_K; kh++)
                for (int kw = 0; kw < A_K; kw++) begin
                  int od, oh, ow;
                  od = id * A_S + kd * A_D - A_P;
                  oh = ih * A_S + kh * A_D - A_P;
                  ow = iw * A_S + kw * A_D - A_P;
                  if (od >= 0 && od < A_OUT && oh >= 0 &&
                      oh < A_OUT && ow >= 0 && ow < A_OUT)
                    exp_q.push_back(pack(
                      ((c * A_N + id) * A_N + ih) * A_N + iw,
                      ((c * A_K + kd) * A_K + kh) * A_K + kw,
                      (od * A_OUT + oh) * A_OUT + ow));
                end

    rst_n   = 1'b0;
    start_a = 1'b0;
    abort_a = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
    tap_a.ready_in = 1'b1;
    tap_b.ready_in = 1'b1;
    #12;
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_valid", int'(tap_a.valid_out), 0);
    check("rst_in", int'(tap_a.in_addr), 0);
    check("rst_w", int'(tap_a.w_addr), 0);
    check("rst_out", int'(tap_a.out_addr), 0);
    check("rst_cnt", int'(cnt_a), 0);
    #10 rst_n = 1'b1;

    // full pass, ready held high
    xi = 0;
    first_t = -1;
    pulse_start_a();
    @(negedge clk);
    check("t1_busy", int'(busy_a), 1);
    check("t1_cnt0", int'(cnt_a), 0);
    wait_done_a(1000, 1'b0, 1'b0, lat);
    check("t1_lat", lat + 1, 218);
    check("t1_busy_at_done", int'(busy_a), 0);
    check("t1_ntrip", xi, 64);
    check("t1_cnt", int'(cnt_a), 64);
    check("t1_first", first_t, pack(0, 13, 31));
    @(negedge clk);
    check("t1_done_1cyc", int'(done_a), 0);

    // same pass under random backpressure
    xi = 0;
    pulse_start_a();
    wait_done_a(3000, 1'b1, 1'b0, lat);
    check("t2_done_seen", int'(lat > 0), 1);
    check("t2_ntrip", xi, 64);
    check("t2_cnt", int'(cnt_a), 64);

    // no-drop configuration on DUT B
    @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    lat = -1;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (done_b) begin
        lat = i;
        break;
      end
    end
    check("t3_lat", lat, 434);
    check("t3_ntrip", nb, 432);
    check("t3_last_out", last_out_b, 63);
    check("t3_cnt", int'(cnt_b), 432);

    // abort on the 10th emitted triple
    xi = 0;
    nd0 = n_done_a;
    found = 1'b0;
    pulse_start_a();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (tap_a.valid_out && xi == 10) begin
        abort_a = 1'b1;
        found = 1'b1;
        break;
      end
    end
    check("t4_found10", int'(found), 1);
    @(negedge clk);
    abort_a = 1'b0;
    check("t4_valid", int'(tap_a.valid_out), 0);
    check("t4_busy", int'(busy_a), 0);
    repeat (5) @(negedge clk);
    check("t4_no_done", n_done_a, nd0);
    xi = 0;
    first_t = -1;
    pulse_start_a();
    @(negedge clk);
    check("t4_cnt_clr", int'(cnt_a), 0);
    wait_done_a(1000, 1'b0, 1'b0, lat);
    check("t4_lat", lat + 1, 218);
    check("t4_first", first_t, pack(0, 13, 31));
    check("t4_cnt", int'(cnt_a), 64);

    // asynchronous reset while a triple is held
    xi = 0;
    found = 1'b0;
    pulse_start_a();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (tap_a.valid_out) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_valid_seen", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_valid", int'(tap_a.valid_out), 0);
    check("t5_busy", int'(busy_a), 0);
    check("t5_in", int'(tap_a.in_addr), 0);
    check("t5_w", int'(tap_a.w_addr), 0);
    check("t5_out", int'(tap_a.out_addr), 0);
    check("t5_cnt", int'(cnt_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    xi = 0;
    pulse_start_a();
    wait_done_a(1000, 1'b0, 1'b0, lat);
    check("t5_lat", lat, 218);
    check("t5_ntrip", xi, 64);
    check("t5_cnt_pass", int'(cnt_a), 64);

    // start while busy and in the DONE cycle is ignored
    xi = 0;
    nd0 = n_done_a;
    pulse_start_a();
    repeat (20) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    wait_done_a(1000, 1'b0, 1'b1, lat);
    check("t6_done_seen", int'(lat > 0), 1);
    repeat (300) @(negedge clk);
    check("t6_one_done", n_done_a, nd0 + 1);
    check("t6_idle", int'(busy_a), 0);
    check("t6_ntrip", xi, 64);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
